// File: rtl/camera_timing_probe_pkg.sv
// Shared constants and helpers for the camera timing probe: measurement
// indices, the block ID word and a saturating 32-bit increment.
package camera_probe_pkg;

    localparam int MEAS_ROWLEN_LINES = 0;
    localparam int MEAS_BYTE_RATE    = 1;
    localparam int MEAS_FRAME_BYTES  = 2;
    localparam int MEAS_FPS_LINES    = 3;
    localparam int MEAS_FRAME_CLKS   = 4;
    localparam int MEAS_ROWLEN_FPS   = 5;
    localparam int MEAS_ERR_COUNT    = 6;
    localparam int MEAS_ID           = 7;
    localparam int MEAS_MAP_SIZE     = 8;

    localparam logic [31:0] PROBE_ID = 32'hCA3E_0001;

    // Holds at all-ones instead of wrapping to zero.
    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (&value) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/camera_timing_probe_sync_edge_detect.sv
// Polarity-normalising edge detector for an already-synchronised strobe.
// rise = inactive->active, fall = active->inactive, both combinational pulses.
module sync_edge_detect #(
    parameter bit ACTIVE_HIGH = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_sig,
    output logic o_rise,
    output logic o_fall
);

    logic w_active;
    logic r_prev_active;

    assign w_active = ACTIVE_HIGH ? i_sig : ~i_sig;

    // The previous level resets to inactive so a held-active input only ever
    // produces a rise, never a spurious fall, when reset is released.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_prev_active <= 1'b0;
        end else begin
            r_prev_active <= w_active;
        end
    end

    assign o_rise = w_active & ~r_prev_active;
    assign o_fall = ~w_active & r_prev_active;

endmodule

// File: rtl/camera_timing_probe.sv
// Camera stream timing probe: measures line/frame geometry and rates, and
// holds one selected measurement as a 32-bit word for a display or probe.
module camera_timing_probe
    import camera_probe_pkg::*;
#(
    parameter int NUM_MEAS       = 8,
    parameter bit HS_ACTIVE_HIGH = 1'b1,
    parameter bit VS_ACTIVE_HIGH = 1'b1,
    parameter int FIELD_W        = 16
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        valid_byte_in,
    input  logic                        hsync_in,
    input  logic                        vsync_in,
    input  logic                        tick_in,
    input  logic                        snapshot_in,
    input  logic                        freeze_in,
    input  logic [$clog2(NUM_MEAS)-1:0] sel_in,
    output logic [31:0]                 display_out,
    output logic                        latched_out,
    output logic                        stale_out
);

    localparam int SEL_W     = $clog2(NUM_MEAS);
    localparam int MAP_DEPTH = 1 << SEL_W;

    function automatic logic [FIELD_W-1:0] sat_field(input logic [FIELD_W-1:0] value);
        return (&value) ? value : value + 1'b1;
    endfunction

    logic w_line_end;
    logic w_frame_start;
    logic w_unused_edges;
    logic w_hs_rise;
    logic w_vs_fall;

    sync_edge_detect #(.ACTIVE_HIGH(HS_ACTIVE_HIGH)) u_hs_edge (
        .i_clk  (clk_in),
        .i_rst  (rst_in),
        .i_sig  (hsync_in),
        .o_rise (w_hs_rise),
        .o_fall (w_line_end)
    );

    sync_edge_detect #(.ACTIVE_HIGH(VS_ACTIVE_HIGH)) u_vs_edge (
        .i_clk  (clk_in),
        .i_rst  (rst_in),
        .i_sig  (vsync_in),
        .o_rise (w_frame_start),
        .o_fall (w_vs_fall)
    );

    assign w_unused_edges = w_hs_rise | w_vs_fall;

    logic [FIELD_W-1:0] r_byte_in_line;
    logic [FIELD_W-1:0] r_lines;
    logic [FIELD_W-1:0] r_frames_tick;
    logic [31:0]        r_bytes_frame;
    logic [31:0]        r_clks_frame;
    logic [31:0]        r_bytes_tick;

    logic [FIELD_W-1:0] r_row_len;
    logic [FIELD_W-1:0] r_frame_lines;
    logic [FIELD_W-1:0] r_fps;
    logic [FIELD_W-1:0] r_err_count;
    logic [31:0]        r_frame_bytes;
    logic [31:0]        r_frame_clks;
    logic [31:0]        r_byte_rate;
    logic               r_frame_open;
    logic               r_frame_valid;

    // Final values include a strobe that lands on the same cycle as the boundary.
    logic [FIELD_W-1:0] w_row_final;
    logic [FIELD_W-1:0] w_lines_final;
    logic [FIELD_W-1:0] w_frames_final;
    logic [31:0]        w_bytes_tick_final;

    assign w_row_final        = valid_byte_in ? sat_field(r_byte_in_line) : r_byte_in_line;
    assign w_lines_final      = w_line_end ? sat_field(r_lines) : r_lines;
    assign w_frames_final     = w_frame_start ? sat_field(r_frames_tick) : r_frames_tick;
    assign w_bytes_tick_final = valid_byte_in ? sat_inc(r_bytes_tick) : r_bytes_tick;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_byte_in_line <= '0;
            r_row_len      <= '0;
        end else if (w_line_end) begin
            r_row_len      <= w_row_final;
            r_byte_in_line <= '0;
        end else begin
            r_byte_in_line <= w_row_final;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_lines       <= '0;
            r_bytes_frame <= '0;
            r_clks_frame  <= '0;
            r_frame_lines <= '0;
            r_frame_bytes <= '0;
            r_frame_clks  <= '0;
            r_err_count   <= '0;
            r_frame_open  <= 1'b0;
            r_frame_valid <= 1'b0;
        end else if (w_frame_start) begin
            r_frame_lines <= w_lines_final;
            r_frame_bytes <= r_bytes_frame;
            r_frame_clks  <= r_clks_frame;
            r_lines       <= '0;
            r_bytes_frame <= valid_byte_in ? 32'd1 : 32'd0;
            r_clks_frame  <= 32'd1;
            r_frame_open  <= 1'b1;
            // Only a frame bounded by two frame starts is a valid reference.
            r_frame_valid <= r_frame_open;
            if (r_frame_valid && (w_lines_final != r_frame_lines)) begin
                r_err_count <= sat_field(r_err_count);
            end
        end else begin
            r_lines       <= w_lines_final;
            r_bytes_frame <= valid_byte_in ? sat_inc(r_bytes_frame) : r_bytes_frame;
            r_clks_frame  <= sat_inc(r_clks_frame);
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_bytes_tick  <= '0;
            r_frames_tick <= '0;
            r_byte_rate   <= '0;
            r_fps         <= '0;
        end else if (tick_in) begin
            r_byte_rate   <= w_bytes_tick_final;
            r_fps         <= w_frames_final;
            r_bytes_tick  <= '0;
            r_frames_tick <= '0;
        end else begin
            r_bytes_tick  <= w_bytes_tick_final;
            r_frames_tick <= w_frames_final;
        end
    end

    logic [31:0] w_map  [0:MEAS_MAP_SIZE-1];
    logic [31:0] w_meas [0:MAP_DEPTH-1];
    logic [31:0] w_live;

    always_comb begin
        w_map[MEAS_ROWLEN_LINES] = 32'({r_frame_lines, r_row_len});
        w_map[MEAS_BYTE_RATE]    = r_byte_rate;
        w_map[MEAS_FRAME_BYTES]  = r_frame_bytes;
        w_map[MEAS_FPS_LINES]    = 32'({r_fps, r_frame_lines});
        w_map[MEAS_FRAME_CLKS]   = r_frame_clks;
        w_map[MEAS_ROWLEN_FPS]   = 32'({r_row_len, r_fps});
        w_map[MEAS_ERR_COUNT]    = 32'(r_err_count);
        w_map[MEAS_ID]           = PROBE_ID;
    end

    // Selector codes beyond the configured map read as zero.
    for (genvar gi = 0; gi < MAP_DEPTH; gi++) begin : g_meas
        if ((gi < NUM_MEAS) && (gi < MEAS_MAP_SIZE)) begin : g_used
            assign w_meas[gi] = w_map[gi];
        end else begin : g_zero
            assign w_meas[gi] = '0;
        end
    end

    assign w_live = w_meas[sel_in];

    logic        w_latch;
    logic [31:0] r_display;
    logic        r_latched;
    logic        r_stale;

    assign w_latch = snapshot_in | (tick_in & ~freeze_in);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_display <= '0;
            r_latched <= 1'b0;
            r_stale   <= 1'b0;
        end else begin
            r_latched <= w_latch;
            if (w_latch) begin
                r_display <= w_live;
                r_stale   <= 1'b0;
            end else if (w_live != r_display) begin
                r_stale   <= 1'b1;
            end
        end
    end

    assign display_out = r_display;
    assign latched_out = r_latched;
    assign stale_out   = r_stale;

endmodule

// File: tb/tb_camera_timing_probe.sv
// Directed bench for camera_timing_probe: frames are generated cycle by cycle
// and each latch is checked against an expected word queued with its strobe.
module tb_camera_timing_probe;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        valid_byte_in;
    logic        hsync_in;
    logic        vsync_in;
    logic        tick_in;
    logic        snapshot_in;
    logic        freeze_in;
    logic [2:0]  sel_in;
    logic [31:0] display_out;
    logic        latched_out;
    logic        stale_out;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];

    always #5 clk_in = ~clk_in;

    camera_timing_probe dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .valid_byte_in (valid_byte_in),
        .hsync_in      (hsync_in),
        .vsync_in      (vsync_in),
        .tick_in       (tick_in),
        .snapshot_in   (snapshot_in),
        .freeze_in     (freeze_in),
        .sel_in        (sel_in),
        .display_out   (display_out),
        .latched_out   (latched_out),
        .stale_out     (stale_out)
    );

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Queue the expected word, pulse the strobe, wait (bounded) for the latch.
    task automatic latch_check(input string tag, input bit use_snap, input logic [31:0] expected);
        int          waited;
        logic [31:0] exp_v;
        exp_q.push_back(expected);
        if (use_snap) snapshot_in = 1'b1;
        else          tick_in     = 1'b1;
        cyc();
        snapshot_in = 1'b0;
        tick_in     = 1'b0;
        waited = 0;
        while (latched_out !== 1'b1 && waited < 4) begin
            cyc();
            waited++;
        end
        exp_v = exp_q.pop_front();
        check({tag, "_latency"}, 32'(waited), 32'd0);
        check(tag, display_out, exp_v);
        $display("latch %s display=%h expected=%h waited=%0d", tag, display_out, exp_v, waited);
    endtask

    task automatic vs_pulse(input bit with_tick);
        vsync_in = 1'b1;
        tick_in  = with_tick;
        cyc();
        tick_in  = 1'b0;
        cyc(3);
        vsync_in = 1'b0;
        cyc();
    endtask

    task automatic send_lines(input int n, input int nbytes, input int idle);
        repeat (n) begin
            hsync_in      = 1'b1;
            valid_byte_in = 1'b1;
            cyc(nbytes);
            hsync_in      = 1'b0;
            valid_byte_in = 1'b0;
            cyc(idle);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int err_lines[4] = '{10, 10, 11, 10};

        rst_in = 1'b1; valid_byte_in = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
        tick_in = 1'b0; snapshot_in = 1'b0; freeze_in = 1'b0; sel_in = 3'd0;
        cyc(2);
        check("reset_display", display_out, 32'd0);
        check("reset_latched", 32'(latched_out), 32'd0);
        check("reset_stale", 32'(stale_out), 32'd0);
        rst_in = 1'b0;
        cyc();

        // One 10x640 frame, closed by the start of the next frame.
        vs_pulse(1'b0);
        send_lines(10, 640, 4);
        vs_pulse(1'b0);
        sel_in = 3'd0;
        cyc();
        latch_check("rowlen_lines", 1'b0, 32'h000A_0280);
        cyc();
        check("latched_one_cycle", 32'(latched_out), 32'd0);
        check("stale_after_tick", 32'(stale_out), 32'd0);

        // Frozen ticks do not latch; a selector change only marks stale.
        freeze_in = 1'b1;
        sel_in    = 3'd2;
        cyc(2);
        check("stale_on_sel", 32'(stale_out), 32'd1);
        repeat (2) begin
            tick_in = 1'b1;
            cyc();
            tick_in = 1'b0;
            check("freeze_no_latch", 32'(latched_out), 32'd0);
            cyc(3);
        end
        check("freeze_display", display_out, 32'h000A_0280);
        check("freeze_stale", 32'(stale_out), 32'd1);
        latch_check("frame_bytes", 1'b1, 32'd6400);
        cyc();
        check("stale_cleared", 32'(stale_out), 32'd0);
        freeze_in = 1'b0;
        sel_in    = 3'd4;
        latch_check("frame_clks", 1'b1, 32'd6445);
        send_lines(10, 8, 1);

        // Frame-rate window: 3 frames, then 3 more plus one coincident with the tick.
        sel_in = 3'd3;
        tick_in = 1'b1;
        cyc();
        tick_in = 1'b0;
        cyc();
        repeat (3) begin
            vs_pulse(1'b0);
            send_lines(10, 128, 4);
        end
        latch_check("fps_prev_window", 1'b0, 32'h0000_000A);
        latch_check("fps3", 1'b1, 32'h0003_000A);
        repeat (3) begin
            vs_pulse(1'b0);
            send_lines(10, 128, 4);
        end
        vs_pulse(1'b1);
        send_lines(10, 128, 4);
        latch_check("fps4_coincident", 1'b1, 32'h0004_000A);

        // Geometry errors: no errors so far, then 10,10,11,10 gives two.
        sel_in = 3'd6;
        latch_check("err_none", 1'b1, 32'd0);
        foreach (err_lines[i]) begin
            vs_pulse(1'b0);
            send_lines(err_lines[i], 8, 1);
        end
        vs_pulse(1'b0);
        latch_check("err_two", 1'b1, 32'd2);

        // Row length saturates instead of wrapping.
        send_lines(1, 65540, 4);
        sel_in = 3'd0;
        latch_check("rowlen_sat", 1'b1, 32'h000A_FFFF);
        sel_in = 3'd7;
        latch_check("block_id", 1'b1, 32'hCA3E_0001);

        // Asynchronous reset mid-line, then a held-active hsync after release.
        sel_in        = 3'd0;
        hsync_in      = 1'b1;
        valid_byte_in = 1'b1;
        cyc(5);
        check("pre_reset_stale", 32'(stale_out), 32'd1);
        #2 rst_in = 1'b1;
        #1;
        check("async_rst_display", display_out, 32'd0);
        check("async_rst_latched", 32'(latched_out), 32'd0);
        check("async_rst_stale", 32'(stale_out), 32'd0);
        cyc(2);
        rst_in = 1'b0;
        cyc(20);
        latch_check("no_spurious_line_end", 1'b1, 32'd0);
        hsync_in      = 1'b0;
        valid_byte_in = 1'b0;
        cyc();
        latch_check("first_real_line_end", 1'b1, 32'd21);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
